debug_inst_sequencer: RTL and testbench

//  Encoder counterpart of the format decoder: converts debug-module abstract commands into
//  RV32I instruction words. The words are streamed into the core's decode stage over a

---
 rtl/debug_inst_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_debug_inst_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_inst_sequencer.sv
// rtl/debug_inst_sequencer.sv - abstract debug command to RV32I instruction stream encoder
module debug_inst_sequencer #(
    parameter logic [11:0] DSCRATCH_CSR = 12'h7B2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_type,
    input  logic [2:0]  i_cmd_funct3,
    input  logic [4:0]  i_cmd_ra,
    input  logic [4:0]  i_cmd_rd,
    input  logic [31:0] i_cmd_addr,
    input  logic        i_abort,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic        o_inst_last,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [1:0] CMD_REG_RD = 2'b00;
    localparam logic [1:0] CMD_REG_WR = 2'b01;
    localparam logic [1:0] CMD_MEM_RD = 2'b10;
    localparam logic [1:0] CMD_MEM_WR = 2'b11;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic        err_q, err_d;
    logic [1:0]  type_q;
    logic [2:0]  f3_q;
    logic [4:0]  ra_q;
    logic [4:0]  rd_q;
    logic [31:0] addr_q;

    logic        accept;
    logic        cmd_legal;
    logic        xfer;
    logic        is_reg;
    logic        word_last;
    logic [31:0] word;
    logic [19:0] hi;
    logic [11:0] lo;

    assign o_cmd_ready = (state_q == S_IDLE) && !i_rst;
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign xfer        = (state_q == S_EMIT) && i_inst_ready;

    // Legality is judged on the live command fields so rejection costs no EMIT cycle.
    always_comb begin
        cmd_legal = 1'b1;
        case (i_cmd_type)
            CMD_MEM_RD: begin
                if (i_cmd_ra == 5'd0) cmd_legal = 1'b0;
                case (i_cmd_funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ;
                    default: cmd_legal = 1'b0;
                endcase
            end
            CMD_MEM_WR: begin
                if (i_cmd_ra == 5'd0)        cmd_legal = 1'b0;
                if (i_cmd_ra == i_cmd_rd)    cmd_legal = 1'b0;
                if (i_cmd_funct3 > 3'b010)   cmd_legal = 1'b0;
            end
            default: cmd_legal = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    step_d = 2'd0;
                    if (cmd_legal) begin
                        state_d = S_EMIT;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                // Abort takes priority over a simultaneous handshake, even on the last word.
                if (i_abort) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else if (xfer) begin
                    if (word_last) begin
                        state_d = S_DONE;
                        err_d   = 1'b0;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 2'd0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
            err_q   <= 1'b0;
            type_q  <= 2'd0;
            f3_q    <= 3'd0;
            ra_q    <= 5'd0;
            rd_q    <= 5'd0;
            addr_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            err_q   <= err_d;
            if (accept) begin
                type_q <= i_cmd_type;
                f3_q   <= i_cmd_funct3;
                ra_q   <= i_cmd_ra;
                rd_q   <= i_cmd_rd;
                addr_q <= i_cmd_addr;
            end
        end
    end

    // The load/store immediate is sign-extended by the core, so round hi up when lo is negative.
    assign hi     = addr_q[31:12] + {19'd0, addr_q[11]};
    assign lo     = addr_q[11:0];
    assign is_reg = (type_q == CMD_REG_RD) || (type_q == CMD_REG_WR);
    assign word_last = is_reg || (step_q == 2'd2);

    always_comb begin
        word = 32'd0;
        case (type_q)
            CMD_REG_RD: word = {DSCRATCH_CSR, rd_q, F3_CSRRW, 5'd0, OP_SYSTEM};
            CMD_REG_WR: word = {DSCRATCH_CSR, 5'd0, F3_CSRRS, rd_q, OP_SYSTEM};
            CMD_MEM_RD: begin
                case (step_q)
                    2'd0:    word = {hi, ra_q, OP_LUI};
                    2'd1:    word = {lo, ra_q, f3_q, rd_q, OP_LOAD};
                    default: word = {DSCRATCH_CSR, rd_q, F3_CSRRW, 5'd0, OP_SYSTEM};
                endcase
            end
            CMD_MEM_WR: begin
                case (step_q)
                    2'd0:    word = {hi, ra_q, OP_LUI};
                    2'd1:    word = {DSCRATCH_CSR, 5'd0, F3_CSRRS, rd_q, OP_SYSTEM};
                    default: word = {lo[11:5], rd_q, ra_q, f3_q, lo[4:0], OP_STORE};
                endcase
            end
            default: word = 32'd0;
        endcase
    end

    assign o_inst_valid = (state_q == S_EMIT);
    assign o_inst       = o_inst_valid ? word : 32'd0;
    assign o_inst_last  = o_inst_valid && word_last;
    assign o_done       = (state_q == S_DONE);
    assign o_err        = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_debug_inst_sequencer.sv
// tb/tb_debug_inst_sequencer.sv - scoreboard bench for debug_inst_sequencer
module tb_debug_inst_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [1:0]  i_cmd_type;
    logic [2:0]  i_cmd_funct3;
    logic [4:0]  i_cmd_ra;
    logic [4:0]  i_cmd_rd;
    logic [31:0] i_cmd_addr;
    logic        i_abort;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic        o_inst_last;
    logic        o_done;
    logic        o_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_words[$];
    logic        exp_err[$];
    logic        done_seen;

    always #5 i_clk = ~i_clk;

    debug_inst_sequencer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_type   (i_cmd_type),
        .i_cmd_funct3 (i_cmd_funct3),
        .i_cmd_ra     (i_cmd_ra),
        .i_cmd_rd     (i_cmd_rd),
        .i_cmd_addr   (i_cmd_addr),
        .i_abort      (i_abort),
        .o_inst_valid (o_inst_valid),
        .i_inst_ready (i_inst_ready),
        .o_inst       (o_inst),
        .o_inst_last  (o_inst_last),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s observed=unexpected expected=none", tag);
    endtask

    task automatic push_word(input logic last, input logic [31:0] w);
        exp_words.push_back({last, w});
    endtask

    // Words are scored before the edge that transfers them; done/err after the edge.
    task automatic tick();
        logic [32:0] e;
        logic        ee;
        if (o_inst_valid && i_inst_ready && !i_abort) begin
            if (exp_words.size() == 0) begin
                fail_now("spurious_word");
            end else begin
                e = exp_words.pop_front();
                check("inst_word", o_inst, e[31:0]);
                check("inst_last", {31'd0, o_inst_last}, {31'd0, e[32]});
            end
        end
        @(posedge i_clk);
        #1;
        if (o_done) begin
            done_seen = 1'b1;
            if (exp_err.size() == 0) begin
                fail_now("spurious_done");
            end else begin
                ee = exp_err.pop_front();
                check("done_err", {31'd0, o_err}, {31'd0, ee});
            end
        end
    endtask

    task automatic send(input logic [1:0] t, input logic [2:0] f3, input logic [4:0] ra,
                        input logic [4:0] rd, input logic [31:0] addr, input int err);
        i_cmd_type   = t;
        i_cmd_funct3 = f3;
        i_cmd_ra     = ra;
        i_cmd_rd     = rd;
        i_cmd_addr   = addr;
        i_cmd_valid  = 1'b1;
        done_seen    = 1'b0;
        if (err >= 0) exp_err.push_back(err[0]);
        tick();
        i_cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_seen; i++) tick();
        check("done_timeout", {31'd0, done_seen}, 32'd1);
    endtask

    initial begin
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_type = 2'd0; i_cmd_funct3 = 3'd0;
        i_cmd_ra = 5'd0; i_cmd_rd = 5'd0; i_cmd_addr = 32'd0; i_abort = 1'b0;
        i_inst_ready = 1'b1; done_seen = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        check("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
        check("rst_valid", {31'd0, o_inst_valid}, 32'd0);
        check("rst_inst", o_inst, 32'd0);
        check("rst_last", {31'd0, o_inst_last}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        i_rst = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, o_cmd_ready}, 32'd1);

        // REG_RD D=5, done exactly two cycles after accept
        push_word(1'b1, 32'h7B229073);
        send(2'b00, 3'd0, 5'd0, 5'd5, 32'd0, 0);
        check("reg_rd_first_valid", {31'd0, o_inst_valid}, 32'd1);
        tick();
        check("reg_rd_done", {31'd0, o_done}, 32'd1);
        check("reg_rd_err", {31'd0, o_err}, 32'd0);
        tick();
        check("idle_ready", {31'd0, o_cmd_ready}, 32'd1);

        // REG_WR D=10
        push_word(1'b1, 32'h7B202573);
        send(2'b01, 3'd0, 5'd0, 5'd10, 32'd0, 0);
        wait_done(10); tick();

        // MEM_RD addr=0x1800
        push_word(1'b0, 32'h00002337);
        push_word(1'b0, 32'h80032383);
        push_word(1'b1, 32'h7B239073);
        send(2'b10, 3'b010, 5'd6, 5'd7, 32'h00001800, 0);
        wait_done(10); tick();

        // MEM_WR with back-pressure on word 2
        push_word(1'b0, 32'h10000337);
        push_word(1'b0, 32'h7B2023F3);
        push_word(1'b1, 32'h00730223);
        send(2'b11, 3'b000, 5'd6, 5'd7, 32'h10000004, 0);
        tick();
        i_inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", {31'd0, o_inst_valid}, 32'd1);
            check("hold_inst", o_inst, 32'h7B2023F3);
            check("hold_last", {31'd0, o_inst_last}, 32'd0);
        end
        i_inst_ready = 1'b1;
        wait_done(10); tick();

        // MEM_RD hi wrap
        push_word(1'b0, 32'h00000337);
        push_word(1'b0, 32'h80032383);
        push_word(1'b1, 32'h7B239073);
        send(2'b10, 3'b010, 5'd6, 5'd7, 32'hFFFFF800, 0);
        wait_done(10); tick();

        // Illegal commands: rejected the cycle after accept with no words
        send(2'b11, 3'b000, 5'd6, 5'd6, 32'h0, 1);
        check("ill_wr_ad_done", {31'd0, o_done}, 32'd1);
        check("ill_wr_ad_valid", {31'd0, o_inst_valid}, 32'd0);
        tick();
        send(2'b10, 3'b011, 5'd6, 5'd7, 32'h0, 1);
        check("ill_rd_f3_done", {31'd0, o_done}, 32'd1);
        tick();
        send(2'b10, 3'b010, 5'd0, 5'd7, 32'h0, 1);
        check("ill_rd_a0_done", {31'd0, o_done}, 32'd1);
        tick();
        send(2'b11, 3'b100, 5'd6, 5'd7, 32'h0, 1);
        check("ill_wr_f3_done", {31'd0, o_done}, 32'd1);
        tick();

        // REG_RD D=0 is legal
        push_word(1'b1, 32'h7B201073);
        send(2'b00, 3'd0, 5'd0, 5'd0, 32'd0, 0);
        wait_done(10); tick();

        // Abort during word 2 of MEM_RD
        push_word(1'b0, 32'h00002337);
        send(2'b10, 3'b010, 5'd6, 5'd7, 32'h00001800, 1);
        tick();
        i_inst_ready = 1'b0;
        check("abort_word2", o_inst, 32'h80032383);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_done", {31'd0, o_done}, 32'd1);
        check("abort_valid_drop", {31'd0, o_inst_valid}, 32'd0);
        tick();
        i_inst_ready = 1'b1;

        // Reset mid-EMIT
        i_inst_ready = 1'b0;
        send(2'b11, 3'b010, 5'd3, 5'd4, 32'h00000040, -1);
        tick();
        check("pre_rst_valid", {31'd0, o_inst_valid}, 32'd1);
        i_rst = 1'b1;
        tick();
        check("midrst_valid", {31'd0, o_inst_valid}, 32'd0);
        check("midrst_inst", o_inst, 32'd0);
        check("midrst_done", {31'd0, o_done}, 32'd0);
        check("midrst_ready", {31'd0, o_cmd_ready}, 32'd0);
        i_rst = 1'b0;
        tick();
        check("after_rst_ready", {31'd0, o_cmd_ready}, 32'd1);
        check("after_rst_done", {31'd0, o_done}, 32'd0);
        i_inst_ready = 1'b1;
        tick();

        check("words_left", exp_words.size(), 32'd0);
        check("errs_left", exp_err.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
